mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between instruction fetch (R0) and data access (R1).
//  - Two-state FSM with round-robin choice, non-preemptive grant, one-cycle DONE response.
//  - Drives the select of the 32-bit 2:1 address and write-data steering muxes.
//  - Generates the stall handshake the pipeline uses when both stages need memory.
// PARAMETERS
//  TIMEOUT_CYC  16  max BUSY cycles without MEM_ACK before abort (used only with MEMARB_TIMEOUT_EN)
//  TMR_W        5   timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYC
// PORTS
//  CLK        in   1   clock; sole clock domain
//  RESET      in   1   synchronous, active-high reset
//  REQ0       in   1   R0 (fetch) request; held until DONE0
//  ADDR0      in   32  R0 address; stable while REQ0=1
//  REQ1       in   1   R1 (data) request; held until DONE1
//  WE1        in   1   R1 write enable; stable while REQ1=1
//  ADDR1      in   32  R1 address
//  WDATA1     in   32  R1 write data
//  DONE0      out  1   one-cycle pulse: R0 transfer complete
//  DONE1      out  1   one-cycle pulse: R1 transfer complete
//  RDATA      out  32  read data, valid while DONE0|DONE1
//  ERR        out  1   with DONE*, transfer aborted by timeout (0 if macro absent)
//  SEL        out  1   mux CONTROL: 1 = R1 drives MEM_ADDR/MEM_WDATA, 0 = R0
//  MEM_REQ    out  1   memory request, high for the whole BUSY state
//  MEM_WE     out  1   WE1 & SEL & MEM_REQ
//  MEM_ADDR   out  32  steered address
//  MEM_WDATA  out  32  steered write data; R0 side tied to 0
//  MEM_ACK    in   1   memory completion, single cycle; RDATA valid in the same cycle
//  MEM_RDATA  in   32  memory read data
// BEHAVIOUR
//  - Reset values: state=IDLE, OWNER=0, LAST=1, MEM_REQ=0, SEL=0, DONE0=DONE1=0, RDATA=0, ERR=0, timer=0.
//  - IDLE: at the edge, eligible requesters are REQx & ~DONEx.
//    - A requester whose DONE is high this cycle is masked, so it cannot be re-granted.
//    - One eligible: grant it. Both eligible: grant ~LAST (round robin). None: stay in IDLE.
//    - On a grant: OWNER<=winner, SEL<=winner, go to BUSY, MEM_REQ=1 from the next cycle.
//  - BUSY: SEL and MEM_REQ hold. New REQs are ignored; there is no preemption.
//    - Edge with MEM_ACK=1: RDATA<=MEM_RDATA, DONE[OWNER]<=1 for one cycle, LAST<=OWNER, go to IDLE.
//    - MEM_REQ drops the cycle after the MEM_ACK.
//  - MEM_ACK during IDLE is ignored; no state change.
//  - Latency: REQ sampled at edge k; MEM_REQ is high in cycles k+1 onward.
//    - ACK at edge m gives DONE in cycle m+1.
//    - Minimum turnaround: REQ to DONE in 2 cycles.
//    - A back-to-back grant to the other requester starts in the DONE cycle.
//  - SEL changes only on an IDLE->BUSY transition, so the steered address is glitch-free for the memory.
//  - RDATA holds its last value between transfers.
//  - Reset mid-BUSY: the RESET edge forces IDLE and MEM_REQ=0; the in-flight transfer is dropped with no DONE.
// CONFIGURATION
//  - MEMARB_TIMEOUT_EN defined: timer clears on entering BUSY and counts every BUSY cycle.
//    - Timer == TIMEOUT_CYC-1 with no ACK: DONE[OWNER]=1, ERR=1, RDATA=0, LAST<=OWNER, go to IDLE.
//    - ACK in that same cycle wins: normal completion, ERR=0.
//  - MEMARB_TIMEOUT_EN undefined: no timer logic, ERR tied to 0, BUSY waits indefinitely for MEM_ACK.
// STRUCTURE
//  - Package memarb_pkg: state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1), REQ_IF=1'b0, REQ_DATA=1'b1.
//  - Sub-module rr_pick2 (combinational): inputs {req[1:0], last}; outputs {gnt_valid, gnt_id}.
//  - Address and write-data steering: two instances of the codebase's 32-bit 2:1 mux (MUX32).
//    - MUX32 convention is CONTROL=1 selects IN1, so IN1=R1 side, IN2=R0 side, CONTROL=SEL.
// TESTING
//  1. Reset, then REQ0=1 ADDR0=0x00400000, ACK 3 cycles after MEM_REQ with MEM_RDATA=0x8C080004
//     -> SEL=0, MEM_ADDR=0x00400000; DONE0 1 cycle; RDATA=0x8C080004.
//  2. REQ0 and REQ1 rise together, both repeat; ACK after 1 cycle each
//     -> grant order R0,R1,R0,R1; never two consecutive grants to one side.
//  3. R1 write, ADDR1=0x10010000, WDATA1=0xDEADBEEF
//     -> SEL=1, MEM_WE=1, MEM_WDATA=0xDEADBEEF; DONE1 pulse; R0 held off (no DONE0) until DONE1.
//  4. RESET asserted in the 2nd BUSY cycle
//     -> next cycle MEM_REQ=0, SEL=0, no DONE; next REQ1 wins (LAST=1 is reset, so R0 wins only a tie).
//  5. MEM_ACK pulse while IDLE and no REQ -> no DONE, RDATA unchanged.
//  6. With MEMARB_TIMEOUT_EN, TIMEOUT_CYC=16, no ACK
//     -> DONE0=1, ERR=1 in cycle 17 after MEM_REQ rose; without the macro, MEM_REQ stays high.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and requester ids.
package memarb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic REQ_IF   = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_pick2
    import memarb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    // Winner selection; the tie case alternates against the last owner.
    always_comb begin
        gnt_valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_id_o = REQ_IF;
            2'b10:   gnt_id_o = REQ_DATA;
            2'b11:   gnt_id_o = ~last_i;
            default: gnt_id_o = REQ_IF;
        endcase
    end

endmodule

// File: rtl/mux32.sv
// 32-bit 2:1 steering mux; CONTROL=1 passes IN1, CONTROL=0 passes IN2.
module MUX32 (
    input  logic        CONTROL,
    input  logic [31:0] IN1,
    input  logic [31:0] IN2,
    output logic [31:0] OUT
);

    assign OUT = CONTROL ? IN1 : IN2;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between fetch (R0) and data (R1) with a non-preemptive
// round-robin grant. Define MEMARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles without MEM_ACK.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TMR_W       = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic [31:0] ADDR0,
    input  logic        REQ1,
    input  logic        WE1,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        SEL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);

    if ((2 ** TMR_W) <= TIMEOUT_CYC) begin : g_tmr_w_check
        $error("TMR_W too narrow for TIMEOUT_CYC");
    end

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        mem_req_q, mem_req_d;
    logic [1:0]  done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  req_elig_s;
    logic        gnt_valid_s;
    logic        gnt_id_s;

`ifdef MEMARB_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    // A requester is masked during its own DONE cycle so it cannot be re-granted immediately.
    assign req_elig_s = {REQ1 & ~done_q[1], REQ0 & ~done_q[0]};

    rr_pick2 u_pick (
        .req_i       (req_elig_s),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    MUX32 u_addr_mux (
        .CONTROL (sel_q),
        .IN1     (ADDR1),
        .IN2     (ADDR0),
        .OUT     (MEM_ADDR)
    );

    MUX32 u_wdata_mux (
        .CONTROL (sel_q),
        .IN1     (WDATA1),
        .IN2     (32'h0000_0000),
        .OUT     (MEM_WDATA)
    );

    // Next-state and registered-output logic of the IDLE/BUSY arbiter.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        sel_d     = sel_q;
        mem_req_d = mem_req_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    owner_d   = gnt_id_s;
                    sel_d     = gnt_id_s;
                    mem_req_d = 1'b1;
                    state_d   = ST_BUSY;
`ifdef MEMARB_TIMEOUT_EN
                    timer_d   = {TMR_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (MEM_ACK) begin
                    rdata_d   = MEM_RDATA;
                    done_d    = id_to_onehot(owner_q);
                    last_d    = owner_q;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (timer_q == TMO_LAST) begin
                    rdata_d   = 32'h0000_0000;
                    done_d    = id_to_onehot(owner_q);
                    err_d     = 1'b1;
                    last_d    = owner_q;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
                end
`else
                else begin
                    state_d = ST_BUSY;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            mem_req_q <= 1'b0;
            done_q    <= 2'b00;
            rdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            mem_req_q <= mem_req_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    // BUSY-cycle counter for the no-ACK abort.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            timer_q <= {TMR_W{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign DONE0   = done_q[0];
    assign DONE1   = done_q[1];
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
    assign SEL     = sel_q;
    assign MEM_REQ = mem_req_q;
    assign MEM_WE  = WE1 & sel_q & mem_req_q;

endmodule
